// File: rtl/clk_mon_pkg.sv
// Shared constants and state encoding for the divided-clock monitor.
// Default timing matches the 250 Hz divider it is paired with.
package clk_mon_pkg;

  localparam int DIV_DEF        = 16;
  localparam int HIGH_DEF       = 8;
  localparam int TOL_DEF        = 1;
  localparam int LOCK_COUNT_DEF = 4;
  localparam int CNT_W_DEF      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } mon_state_t;

endpackage

// File: rtl/clk_edge_sync.sv
// Two-flop synchroniser with edge detect and registered rise/fall strobes.
// The raw edge events are exported so same-cycle logic can act on them.
module clk_edge_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise_ev,
  output logic o_fall_ev,
  output logic o_rise_stb,
  output logic o_fall_stb
);

  logic r_s1;
  logic r_s2;
  logic r_prev;
  logic r_rise_stb;
  logic r_fall_stb;
  logic w_rise_ev;
  logic w_fall_ev;

  assign w_rise_ev = r_s2 & ~r_prev;
  assign w_fall_ev = ~r_s2 & r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_prev     <= 1'b0;
      r_rise_stb <= 1'b0;
      r_fall_stb <= 1'b0;
    end else begin
      r_s1       <= i_async;
      r_s2       <= r_s1;
      r_prev     <= r_s2;
      r_rise_stb <= w_rise_ev;
      r_fall_stb <= w_fall_ev;
    end
  end

  assign o_rise_ev  = w_rise_ev;
  assign o_fall_ev  = w_fall_ev;
  assign o_rise_stb = r_rise_stb;
  assign o_fall_stb = r_fall_stb;

endmodule

// File: rtl/clk_250hz_monitor.sv
// Monitors a slow divided clock: edge strobes, period/high-time checks,
// lock after consecutive good periods, sticky fault flag.
//
//   state   | meaning
//   IDLE    | no reference rise yet (after reset or stall)
//   ACQ     | counting consecutive good periods
//   LOCK    | slow clock within tolerance; faults set ERROR
module clk_250hz_monitor
  import clk_mon_pkg::*;
#(
  parameter int DIV        = DIV_DEF,
  parameter int HIGH       = HIGH_DEF,
  parameter int TOL        = TOL_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clk_slow,
  input  logic             i_err_clr,
  output logic             o_rise_stb,
  output logic             o_fall_stb,
  output logic             o_locked,
  output logic             o_error,
  output logic [CNT_W-1:0] o_period
);

  localparam int CW1  = CNT_W + 1;
  localparam int GC_W = $clog2(LOCK_COUNT + 1);

  localparam logic signed [CNT_W:0] LP_DIV  = $signed(CW1'(DIV));
  localparam logic signed [CNT_W:0] LP_HIGH = $signed(CW1'(HIGH));
  localparam logic signed [CNT_W:0] LP_TOL  = $signed(CW1'(TOL));
  localparam logic [CNT_W-1:0]      LP_TMO  = CNT_W'(DIV + TOL + 1);
  localparam logic [GC_W-1:0]       LP_GC_LAST = GC_W'(LOCK_COUNT - 1);

  mon_state_t r_state;
  mon_state_t w_state_nxt;
  logic [GC_W-1:0]  r_good_cnt;
  logic [GC_W-1:0]  w_good_cnt_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hi_meas;
  logic [CNT_W-1:0] r_period;
  logic             r_error;

  logic w_rise_ev;
  logic w_fall_ev;
  logic signed [CNT_W:0] w_per_dev;
  logic signed [CNT_W:0] w_hi_dev;
  logic w_good;
  logic w_timeout;
  logic w_fault;
  logic w_locked;

  clk_edge_sync u_sync (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_async    (i_clk_slow),
    .o_rise_ev  (w_rise_ev),
    .o_fall_ev  (w_fall_ev),
    .o_rise_stb (o_rise_stb),
    .o_fall_stb (o_fall_stb)
  );

  // One extra bit keeps the signed deviation free of wrap-around.
  assign w_per_dev = $signed({1'b0, r_cnt}) - LP_DIV;
  assign w_hi_dev  = $signed({1'b0, r_hi_meas}) - LP_HIGH;
  assign w_good    = (w_per_dev <= LP_TOL) && (w_per_dev >= -LP_TOL) &&
                     (w_hi_dev  <= LP_TOL) && (w_hi_dev  >= -LP_TOL);
  assign w_timeout = (r_cnt == LP_TMO) && !w_rise_ev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_good_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_good_cnt_nxt = r_good_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_rise_ev) begin
          w_state_nxt    = ST_ACQ;
          w_good_cnt_nxt = '0;
        end
      end
      ST_ACQ: begin
        if (w_rise_ev) begin
          if (!w_good) begin
            w_good_cnt_nxt = '0;
          end else if (r_good_cnt == LP_GC_LAST) begin
            w_state_nxt    = ST_LOCK;
            w_good_cnt_nxt = '0;
          end else begin
            w_good_cnt_nxt = r_good_cnt + 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (w_rise_ev && !w_good) begin
          w_state_nxt    = ST_ACQ;
          w_good_cnt_nxt = '0;
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_good_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_locked = (r_state == ST_LOCK);
    w_fault  = w_locked && ((w_rise_ev && !w_good) || w_timeout);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_hi_meas <= '0;
      r_period  <= '0;
      r_error   <= 1'b0;
    end else begin
      if (w_rise_ev) begin
        r_cnt <= CNT_W'(1);
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_fall_ev) begin
        r_hi_meas <= r_cnt;
      end
      if (w_rise_ev && (r_state != ST_IDLE)) begin
        r_period <= r_cnt;
      end
      // A fault in the same cycle as a clear must not be lost.
      if (w_fault) begin
        r_error <= 1'b1;
      end else if (i_err_clr) begin
        r_error <= 1'b0;
      end
    end
  end

  assign o_locked = w_locked;
  assign o_error  = r_error;
  assign o_period = r_period;

endmodule

// File: tb/tb_clk_250hz_monitor.sv
// Directed bench for clk_250hz_monitor: lock-up, tolerance edges, period,
// duty and stall faults, error clear and reset while locked.
module tb_clk_250hz_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_slow = 1'b0;
  logic       err_clr = 1'b0;
  logic       rise_stb;
  logic       fall_stb;
  logic       locked;
  logic       error;
  logic [7:0] period;

  int n_chk = 0;
  int n_pass = 0;
  int n_per = 0;

  always #5 clk = ~clk;

  clk_250hz_monitor #(
    .DIV        (16),
    .HIGH       (8),
    .TOL        (1),
    .LOCK_COUNT (4),
    .CNT_W      (8)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_clk_slow (clk_slow),
    .i_err_clr  (err_clr),
    .o_rise_stb (rise_stb),
    .o_fall_stb (fall_stb),
    .o_locked   (locked),
    .o_error    (error),
    .o_period   (period)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One slow period of h high / l low cycles; expectations apply at its rise strobe
  // and reflect the previous period's measurement.
  task automatic run_period(input int h, input int l, input int xl, input int xe, input int xp);
    n_per++;
    clk_slow = 1'b1;
    tick(3);
    check($sformatf("p%0d rise_stb", n_per), rise_stb, 1);
    check($sformatf("p%0d locked", n_per), locked, xl);
    check($sformatf("p%0d error", n_per), error, xe);
    check($sformatf("p%0d period", n_per), period, xp);
    tick(1);
    check($sformatf("p%0d rise_stb_1cyc", n_per), rise_stb, 0);
    tick(h - 4);
    clk_slow = 1'b0;
    tick(3);
    check($sformatf("p%0d fall_stb", n_per), fall_stb, 1);
    tick(l - 3);
  endtask

  task automatic clear_err(input string tag);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check({tag, " err_clr"}, error, 0);
    check({tag, " locked_kept"}, locked, 1);
  endtask

  initial begin
    tick(3);
    check("rst rise_stb", rise_stb, 0);
    check("rst fall_stb", fall_stb, 0);
    check("rst locked", locked, 0);
    check("rst error", error, 0);
    check("rst period", period, 0);
    reset = 1'b0;
    tick(20);

    // ideal /16 acquisition: lock on the fifth rise
    run_period(8, 8, 0, 0, 0);
    run_period(8, 8, 0, 0, 16);
    run_period(8, 8, 0, 0, 16);
    run_period(8, 8, 0, 0, 16);
    run_period(8, 8, 1, 0, 16);
    // tolerance boundaries stay locked
    run_period(8, 7, 1, 0, 16);
    run_period(8, 9, 1, 0, 15);
    run_period(7, 8, 1, 0, 17);
    run_period(8, 8, 1, 0, 15);
    run_period(9, 7, 1, 0, 16);
    // 19-cycle period stalls past the timeout just before its rise
    run_period(8, 11, 1, 0, 16);
    run_period(8, 8, 0, 1, 16);
    run_period(8, 8, 0, 1, 16);
    run_period(8, 8, 0, 1, 16);
    run_period(8, 8, 0, 1, 16);
    run_period(8, 7, 1, 1, 16);
    clear_err("relock1");
    run_period(8, 8, 1, 0, 16);

    // duty fault: 11 high / 5 low
    run_period(11, 5, 1, 0, 16);
    run_period(8, 8, 0, 1, 16);
    run_period(8, 8, 0, 1, 16);
    run_period(8, 8, 0, 1, 16);
    run_period(8, 8, 0, 1, 16);
    run_period(8, 7, 1, 1, 16);
    clear_err("relock2");
    run_period(8, 6, 1, 0, 16);

    // short period fault coincident with err_clr: fault wins
    clk_slow = 1'b1;
    tick(2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("clr+fault rise_stb", rise_stb, 1);
    check("clr+fault locked", locked, 0);
    check("clr+fault error", error, 1);
    check("clr+fault period", period, 14);
    tick(5);
    clk_slow = 1'b0;
    tick(8);
    run_period(8, 8, 0, 1, 16);
    run_period(8, 8, 0, 1, 16);
    run_period(8, 8, 0, 1, 16);
    run_period(8, 7, 1, 1, 16);
    clear_err("relock3");
    run_period(8, 8, 1, 0, 16);

    // stuck high: timeout 18 cycles after the last rise event
    clk_slow = 1'b1;
    tick(3);
    check("stuck rise_stb", rise_stb, 1);
    check("stuck locked0", locked, 1);
    check("stuck period", period, 16);
    tick(17);
    check("stuck pre_tmo locked", locked, 1);
    check("stuck pre_tmo error", error, 0);
    tick(1);
    check("stuck tmo locked", locked, 0);
    check("stuck tmo error", error, 1);
    tick(10);
    check("stuck hold locked", locked, 0);
    check("stuck hold error", error, 1);
    clk_slow = 1'b0;
    tick(8);
    run_period(8, 8, 0, 1, 16);
    run_period(8, 8, 0, 1, 16);
    run_period(8, 8, 0, 1, 16);
    run_period(8, 8, 0, 1, 16);
    run_period(8, 8, 1, 1, 16);

    // reset while locked discards everything
    clk_slow = 1'b1;
    tick(3);
    check("prerst locked", locked, 1);
    reset = 1'b1;
    clk_slow = 1'b0;
    tick(1);
    reset = 1'b0;
    check("midrst rise_stb", rise_stb, 0);
    check("midrst fall_stb", fall_stb, 0);
    check("midrst locked", locked, 0);
    check("midrst error", error, 0);
    check("midrst period", period, 0);
    run_period(8, 8, 0, 0, 0);
    run_period(8, 8, 0, 0, 16);
    run_period(8, 8, 0, 0, 16);
    run_period(8, 8, 0, 0, 16);
    run_period(8, 8, 1, 0, 16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
